// File: rtl/itch_msg_assembler_if.sv
// itch_msg_assembler_if: MoldUDP64 beat input and assembled ITCH message output.
interface itch_msg_assembler_if #(
    parameter int AXI_DATA_W = 64,
    parameter int MSG_MAX_W  = 400,
    parameter int LEN_W      = 6
);
    localparam int AXI_KEEP_W = AXI_DATA_W / 8;
    logic                  mold_itch_msg_v;
    logic                  mold_itch_msg_start;
    logic [AXI_KEEP_W-1:0] mold_itch_msg_mask;
    logic [AXI_DATA_W-1:0] mold_itch_msg_data;
    logic                  itch_msg_v;
    logic [7:0]            itch_msg_type;
    logic [LEN_W-1:0]      itch_msg_len;
    logic [MSG_MAX_W-1:0]  itch_msg_data;
    logic                  itch_msg_err;
    modport slave (
        input  mold_itch_msg_v, mold_itch_msg_start, mold_itch_msg_mask, mold_itch_msg_data,
        output itch_msg_v, itch_msg_type, itch_msg_len, itch_msg_data, itch_msg_err
    );
    modport master (
        output mold_itch_msg_v, mold_itch_msg_start, mold_itch_msg_mask, mold_itch_msg_data,
        input  itch_msg_v, itch_msg_type, itch_msg_len, itch_msg_data, itch_msg_err
    );
endinterface

// File: rtl/itch_msg_assembler.sv
// itch_msg_assembler: rebuilds whole ITCH 5.0 messages from mold beats into one wide word,
// flagging and dropping unknown or truncated messages.
module itch_msg_assembler #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int MSG_MAX_W  = 400,
    parameter int CNT_MAX    = 7,
    parameter int LEN_W      = 6
) (
    input logic clk,
    input logic nreset,
    itch_msg_assembler_if.slave bus
);
    localparam int BUF_W = CNT_MAX * AXI_DATA_W;
    localparam int PC_W  = $clog2(AXI_KEEP_W + 1);
    localparam int IDX_W = $clog2(CNT_MAX + 1);
    localparam int MSG_B = MSG_MAX_W / 8;

    typedef enum logic [1:0] {IDLE, ASM, DROP} state_t;

    state_t                r_state, w_state_nxt;
    logic [MSG_MAX_W-1:0]  r_buf, w_buf_nxt, w_msg;
    logic [LEN_W-1:0]      r_cnt, w_cnt_nxt, r_exp, w_exp_nxt, w_len_lu;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt;
    logic [AXI_DATA_W-1:0] w_beat;
    logic [PC_W-1:0]       w_pc;
    logic                  w_done, w_err;
    logic                  r_v, r_err;
    logic [7:0]            r_type;
    logic [LEN_W-1:0]      r_len;
    logic [MSG_MAX_W-1:0]  r_data;

    function automatic logic [LEN_W-1:0] f_len(input logic [7:0] t);
        case (t)
            "S": f_len = LEN_W'(12);
            "R": f_len = LEN_W'(39);
            "H": f_len = LEN_W'(25);
            "Y": f_len = LEN_W'(20);
            "L": f_len = LEN_W'(26);
            "V": f_len = LEN_W'(35);
            "W": f_len = LEN_W'(12);
            "K": f_len = LEN_W'(28);
            "J": f_len = LEN_W'(35);
            "h": f_len = LEN_W'(21);
            "A": f_len = LEN_W'(36);
            "F": f_len = LEN_W'(40);
            "E": f_len = LEN_W'(31);
            "C": f_len = LEN_W'(36);
            "X": f_len = LEN_W'(23);
            "D": f_len = LEN_W'(19);
            "U": f_len = LEN_W'(35);
            "P": f_len = LEN_W'(44);
            "Q": f_len = LEN_W'(40);
            "B": f_len = LEN_W'(19);
            "I": f_len = LEN_W'(50);
            "N": f_len = LEN_W'(20);
            "O": f_len = LEN_W'(48);
            default: f_len = '0;
        endcase
    endfunction

    // Unmasked bytes are zeroed so junk never leaks into the message word.
    always_comb begin
        w_beat = '0;
        for (int j = 0; j < AXI_KEEP_W; j++)
            w_beat[8*j +: 8] = bus.mold_itch_msg_mask[j] ? bus.mold_itch_msg_data[8*j +: 8] : 8'h00;
    end

    assign w_pc     = PC_W'($countones(bus.mold_itch_msg_mask));
    assign w_len_lu = f_len(bus.mold_itch_msg_data[7:0]);

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_exp_nxt   = r_exp;
        w_done      = 1'b0;
        w_err       = 1'b0;
        if (bus.mold_itch_msg_v && bus.mold_itch_msg_start) begin
            w_buf_nxt   = MSG_MAX_W'(w_beat);
            w_cnt_nxt   = LEN_W'(w_pc);
            w_idx_nxt   = IDX_W'(1);
            w_exp_nxt   = w_len_lu;
            w_done      = (w_len_lu != '0) && (w_cnt_nxt >= w_len_lu);
            // Unknown type and truncation of an open message collapse into one pulse.
            w_err       = (w_len_lu == '0) || (r_state == ASM);
            w_state_nxt = (w_len_lu == '0) ? DROP : (w_done ? IDLE : ASM);
        end else if (bus.mold_itch_msg_v && r_state == ASM) begin
            w_buf_nxt   = r_buf | MSG_MAX_W'({{(BUF_W-AXI_DATA_W){1'b0}}, w_beat} << (AXI_DATA_W * r_idx));
            w_cnt_nxt   = r_cnt + LEN_W'(w_pc);
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_done      = w_cnt_nxt >= r_exp;
            w_err       = !w_done && (r_idx == IDX_W'(CNT_MAX - 1));
            w_state_nxt = w_done ? IDLE : (w_err ? DROP : ASM);
        end
    end

    always_comb begin
        w_msg = '0;
        for (int k = 0; k < MSG_B; k++)
            w_msg[8*k +: 8] = (k < int'(w_exp_nxt)) ? w_buf_nxt[8*k +: 8] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_exp   <= '0;
            r_v     <= 1'b0;
            r_err   <= 1'b0;
            r_type  <= '0;
            r_len   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_exp   <= w_exp_nxt;
            r_v     <= w_done;
            r_err   <= w_err;
            if (w_done) begin
                r_type <= w_buf_nxt[7:0];
                r_len  <= w_exp_nxt;
                r_data <= w_msg;
            end
        end
    end

    assign bus.itch_msg_v    = r_v;
    assign bus.itch_msg_err  = r_err;
    assign bus.itch_msg_type = r_type;
    assign bus.itch_msg_len  = r_len;
    assign bus.itch_msg_data = r_data;
endmodule

// File: tb/tb_itch_msg_assembler.sv
// tb_itch_msg_assembler: directed beat sequences with a cycle-stamped scoreboard for
// message and error pulses.
module tb_itch_msg_assembler;
    typedef struct {
        int          cyc;
        logic [7:0]  t;
        logic [5:0]  l;
        logic [399:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    exp_t q_msg[$];
    int   q_err[$];
    logic [7:0] m[64];

    itch_msg_assembler_if bus ();

    itch_msg_assembler dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [399:0] exp_data(input int len);
        logic [399:0] d = '0;
        for (int k = 0; k < len; k++) d[8*k +: 8] = m[k];
        return d;
    endfunction

    task automatic new_msg(input logic [7:0] t);
        for (int k = 0; k < 64; k++) m[k] = 8'($urandom);
        m[0] = t;
    endtask

    // Drives one beat at the falling edge; len/er register what that beat should produce.
    task automatic beat(input bit st, input logic [7:0] mk, input int idx,
                        input int len = 0, input bit er = 0, input bit rl = 0);
        @(negedge clk);
        nreset = !rl;
        bus.mold_itch_msg_v     = 1'b1;
        bus.mold_itch_msg_start = st;
        bus.mold_itch_msg_mask  = mk;
        for (int j = 0; j < 8; j++) bus.mold_itch_msg_data[8*j +: 8] = m[8*idx + j];
        if (len != 0) q_msg.push_back('{cyc + 1, m[0], 6'(len), exp_data(len)});
        if (er) q_err.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.mold_itch_msg_v     = 1'b0;
            bus.mold_itch_msg_start = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (q_msg.size() > 0 && q_msg[0].cyc < cyc) begin
            chk("msg_missing_cyc", cyc, q_msg[0].cyc);
            void'(q_msg.pop_front());
        end
        if (q_err.size() > 0 && q_err[0] < cyc) begin
            chk("err_missing_cyc", cyc, q_err[0]);
            void'(q_err.pop_front());
        end
        if (bus.itch_msg_v) begin
            if (q_msg.size() == 0) chk("msg_unexpected", bus.itch_msg_v, 0);
            else begin
                chk("msg_cyc", cyc, q_msg[0].cyc);
                chk("msg_type", bus.itch_msg_type, q_msg[0].t);
                chk("msg_len", bus.itch_msg_len, q_msg[0].l);
                chk("msg_data", bus.itch_msg_data, q_msg[0].d);
                void'(q_msg.pop_front());
            end
        end
        if (bus.itch_msg_err) begin
            if (q_err.size() == 0) chk("err_unexpected", bus.itch_msg_err, 0);
            else begin
                chk("err_cyc", cyc, q_err[0]);
                void'(q_err.pop_front());
            end
        end
    end

    initial begin
        bus.mold_itch_msg_v     = 1'b0;
        bus.mold_itch_msg_start = 1'b0;
        bus.mold_itch_msg_mask  = '0;
        bus.mold_itch_msg_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_v", bus.itch_msg_v, 0);
        chk("rst_err", bus.itch_msg_err, 0);
        chk("rst_type", bus.itch_msg_type, 0);
        chk("rst_len", bus.itch_msg_len, 0);
        chk("rst_data", bus.itch_msg_data, 0);
        nreset = 1'b1;
        // System event, 12 bytes over two beats
        new_msg(8'h53);
        beat(1, 8'hFF, 0);
        beat(0, 8'h0F, 1, 12);
        idle(3);
        chk("hold_len", bus.itch_msg_len, 12);
        chk("hold_type", bus.itch_msg_type, 8'h53);
        // Add order with an idle gap mid-message
        new_msg(8'h41);
        beat(1, 8'hFF, 0);
        beat(0, 8'hFF, 1);
        beat(0, 8'hFF, 2);
        idle(1);
        beat(0, 8'hFF, 3);
        beat(0, 8'h0F, 4, 36);
        idle(2);
        // Unknown type dropped, continuation beats ignored, then a clean 'D'
        new_msg(8'h7A);
        beat(1, 8'hFF, 0, 0, 1);
        for (int i = 1; i < 4; i++) beat(0, 8'hFF, i);
        new_msg(8'h44);
        beat(1, 8'hFF, 0);
        beat(0, 8'hFF, 1);
        beat(0, 8'h07, 2, 19);
        idle(2);
        // 'P' truncated by a new 'S' start
        new_msg(8'h50);
        beat(1, 8'hFF, 0);
        beat(0, 8'hFF, 1);
        beat(0, 8'hFF, 2);
        new_msg(8'h53);
        beat(1, 8'hFF, 0, 0, 1);
        beat(0, 8'h0F, 1, 12);
        idle(2);
        // Back-to-back 'D' then 'X'
        new_msg(8'h44);
        beat(1, 8'hFF, 0);
        beat(0, 8'hFF, 1);
        beat(0, 8'h07, 2, 19);
        new_msg(8'h58);
        beat(1, 8'hFF, 0);
        beat(0, 8'hFF, 1);
        beat(0, 8'h7F, 2, 23);
        // 'D' with an overlong final beat
        new_msg(8'h44);
        beat(1, 8'hFF, 0);
        beat(0, 8'hFF, 1);
        beat(0, 8'hFF, 2, 19);
        idle(2);
        // Reset during beat 4 of 'I'
        new_msg(8'h49);
        beat(1, 8'hFF, 0);
        for (int i = 1; i < 4; i++) beat(0, 8'hFF, i);
        beat(0, 8'hFF, 4, 0, 0, 1);
        @(negedge clk);
        chk("mid_rst_v", bus.itch_msg_v, 0);
        chk("mid_rst_err", bus.itch_msg_err, 0);
        chk("mid_rst_type", bus.itch_msg_type, 0);
        chk("mid_rst_len", bus.itch_msg_len, 0);
        chk("mid_rst_data", bus.itch_msg_data, 0);
        nreset = 1'b1;
        bus.mold_itch_msg_v = 1'b0;
        beat(0, 8'hFF, 5);
        beat(0, 8'h03, 6);
        idle(4);
        chk("msg_queue_drained", q_msg.size(), 0);
        chk("err_queue_drained", q_err.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
